// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded lock burst. It drives a registered one-hot
// grant and the matching 5-bit mux select, which parks on IDLE_SEL when no source owns the bus.
module bus_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4,
  parameter int IDLE_SEL = 31
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] req,
  input  logic               lock,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   Sout,
  output logic               busy,
  output logic [3:0]         hold_cnt
);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  localparam logic [SEL_W-1:0] LAST_SRC  = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W-1:0] PARK_SEL  = SEL_W'(IDLE_SEL);
  localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);
  localparam logic [3:0]       HOLD_LIM  = 4'(MAX_HOLD - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [SEL_W-1:0]     sout_q, sout_d;
  logic [3:0]           hold_q, hold_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;

  logic [SEL_W-1:0]     start_idx;
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [2*NUM_SRC-1:0] rot_full;
  logic [NUM_SRC-1:0]   rot;
  logic [SEL_W-1:0]     off;
  logic [SEL_W:0]       sum;
  logic [SEL_W-1:0]     win_idx;
  logic [NUM_SRC-1:0]   win_onehot;
  logic                 any_req;
  logic                 owner_req;

  // The search always starts just past the last grant. While a source owns the bus,
  // last equals the owner, so the owner automatically gets the lowest priority.
  assign start_idx = (last_q == LAST_SRC) ? '0 : last_q + 1'b1;
  assign req_dbl   = {req, req};
  assign rot_full  = req_dbl >> start_idx;
  assign rot       = rot_full[NUM_SRC-1:0];
  assign any_req   = |req;
  assign owner_req = |(grant_q & req);

  always_comb begin
    off = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
  end

  assign sum     = {1'b0, start_idx} + {1'b0, off};
  assign win_idx = (sum >= NUM_SRC_W) ? SEL_W'(sum - NUM_SRC_W) : sum[SEL_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_dec
      assign win_onehot[gi] = (win_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sout_d  = sout_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_OWNED;
          last_d  = win_idx;
          sout_d  = win_idx;
          grant_d = win_onehot;
          hold_d  = '0;
        end
      end
      ST_OWNED: begin
        if (owner_req && lock && (hold_q < HOLD_LIM)) begin
          hold_d = hold_q + 4'd1;
        end else if (any_req) begin
          last_d  = win_idx;
          sout_d  = win_idx;
          grant_d = win_onehot;
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
          sout_d  = PARK_SEL;
          grant_d = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = PARK_SEL;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_SRC;
      sout_q  <= PARK_SEL;
      hold_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sout_q  <= sout_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign grant    = grant_q;
  assign Sout     = sout_q;
  assign busy     = |grant_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by random traffic. All outputs are
// compared every cycle against a rule-level model that tracks the owner, the last grant and the hold count.
module tb_bus_arbiter;

  localparam int N        = 24;
  localparam int MAX_HOLD = 4;
  localparam int IDLE_SEL = 31;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] req;
  logic         lock;
  logic [N-1:0] grant;
  logic [4:0]   Sout;
  logic         busy;
  logic [3:0]   hold_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model state: owner is -1 while the bus is idle.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_hold  = 0;

  bus_arbiter #(.NUM_SRC(N), .SEL_W(5), .MAX_HOLD(MAX_HOLD), .IDLE_SEL(IDLE_SEL)) dut (
    .clk(clk), .clr(clr), .req(req), .lock(lock),
    .grant(grant), .Sout(Sout), .busy(busy), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_search(input int base, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (base + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_update(input logic c, input logic [N-1:0] r, input logic l);
    int w;
    if (c) begin
      m_owner = -1; m_last = N - 1; m_hold = 0;
    end else if (m_owner < 0) begin
      w = rr_search(m_last, r);
      if (w >= 0) begin m_owner = w; m_last = w; m_hold = 0; end
    end else if (r[m_owner] && l && (m_hold < MAX_HOLD - 1)) begin
      m_hold = m_hold + 1;
    end else begin
      w = rr_search(m_owner, r);
      m_hold = 0;
      if (w >= 0) begin m_owner = w; m_last = w; end
      else m_owner = -1;
    end
  endtask

  // Applies one cycle of inputs, then compares every output with the model just after the edge.
  task automatic step(input string tag, input logic c, input logic [N-1:0] r, input logic l);
    logic [N-1:0] exp_grant;
    clr = c; req = r; lock = l;
    @(posedge clk);
    model_update(c, r, l);
    #1;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check({tag, ".Sout"}, 32'(Sout), (m_owner < 0) ? 32'(IDLE_SEL) : 32'(m_owner));
    check({tag, ".busy"}, 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
    check({tag, ".hold"}, 32'(hold_cnt), 32'(m_hold));
    $display("step %s clr=%0b req=%06h lock=%0b -> Sout=%0d hold=%0d busy=%0b",
             tag, c, r, l, Sout, hold_cnt, busy);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] ones;
    ones = '1;
    clr = 1'b1; req = '0; lock = 1'b0;

    // Reset with everybody requesting, then the first grant goes to index 0.
    step("reset0", 1'b1, ones, 1'b0);
    step("reset1", 1'b1, ones, 1'b0);
    check("reset.Sout_lit", 32'(Sout), 32'd31);
    step("first", 1'b0, ones, 1'b0);
    check("first.Sout_lit", 32'(Sout), 32'd0);

    // Single requester PC (bit 20).
    step("rst_pc", 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("pc", 1'b0, N'(1) << 20, 1'b0);
      check("pc.Sout_lit", 32'(Sout), 32'd20);
    end
    step("pc_drop", 1'b0, '0, 1'b0);
    check("pc_drop.busy_lit", 32'(busy), 32'd0);

    // Rotation with wrap: prime last=5, then bits 0, 5, 23.
    step("rot_prime", 1'b0, N'(1) << 5, 1'b0);
    r = (N'(1) << 0) | (N'(1) << 5) | (N'(1) << 23);
    step("rot", 1'b0, r, 1'b0); check("rot.a", 32'(Sout), 32'd23);
    step("rot", 1'b0, r, 1'b0); check("rot.b", 32'(Sout), 32'd0);
    step("rot", 1'b0, r, 1'b0); check("rot.c", 32'(Sout), 32'd5);
    step("rot", 1'b0, r, 1'b0); check("rot.d", 32'(Sout), 32'd23);

    // Lock burst: owner 2 keeps the bus for MAX_HOLD cycles, then 9 takes it.
    step("burst_rst", 1'b1, '0, 1'b0);
    step("burst_own", 1'b0, N'(1) << 2, 1'b1);
    r = (N'(1) << 2) | (N'(1) << 9);
    for (int i = 0; i < 3; i++) step("burst", 1'b0, r, 1'b1);
    check("burst.hold_lit", 32'(hold_cnt), 32'd3);
    step("burst_end", 1'b0, r, 1'b1);
    check("burst_end.Sout_lit", 32'(Sout), 32'd9);

    // Lock with no contender: hold count wraps back to 0, owner unchanged.
    for (int i = 0; i < 9; i++) step("lock_solo", 1'b0, N'(1) << 2, 1'b1);

    // clr in the middle of a burst owned by 17.
    step("mid_rst", 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) step("mid_burst", 1'b0, N'(1) << 17, 1'b1);
    step("mid_clr", 1'b1, N'(1) << 17, 1'b1);
    step("mid_after", 1'b0, N'(1) << 17, 1'b0);
    check("mid_after.Sout_lit", 32'(Sout), 32'd17);

    // Full rotation: every source once per N cycles.
    for (int i = 0; i < 2 * N; i++) step("all", 1'b0, ones, 1'b0);

    // Random traffic with a mix of densities, lock and occasional clr.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = N'($urandom);
        default: r = N'($urandom) & N'($urandom) & N'($urandom);
      endcase
      step("rand", ($urandom_range(0, 59) == 0), r, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
